// File: rtl/lfsr_scrambler_pkg.sv
// Shared constants for the parallel self-synchronising scrambler: mode encoding
// and the default x^7+x^4+1 polynomial and seed.
package lfsr_scrambler_pkg;

  localparam logic MODE_SCRAMBLE   = 1'b0;
  localparam logic MODE_DESCRAMBLE = 1'b1;

  localparam int         DEFAULT_LFSR_LEN = 7;
  localparam int         DEFAULT_DATA_W   = 8;
  localparam logic [6:0] DEFAULT_TAPS     = 7'b1001000;
  localparam logic [6:0] DEFAULT_SEED     = 7'b1010000;

endpackage

// File: rtl/lfsr_step_unroll.sv
// Combinational unroll of DATA_W multiplicative scrambler bit-steps; bit 0 of
// data_i is processed first, so it sees the oldest LFSR state.
import lfsr_scrambler_pkg::*;

module lfsr_step_unroll #(
  parameter int                  LFSR_LEN = DEFAULT_LFSR_LEN,
  parameter logic [LFSR_LEN-1:0] TAPS     = DEFAULT_TAPS,
  parameter int                  DATA_W   = DEFAULT_DATA_W
) (
  input  logic [LFSR_LEN-1:0] state_i,
  input  logic [DATA_W-1:0]   data_i,
  input  logic                mode_i,
  output logic [LFSR_LEN-1:0] state_o,
  output logic [DATA_W-1:0]   y_o
);

  logic [LFSR_LEN-1:0] s;
  logic [DATA_W-1:0]   y_c;
  logic                fb;
  logic                shift_in;

  always_comb begin
    s        = state_i;
    y_c      = '0;
    fb       = 1'b0;
    shift_in = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      fb     = ^(s & TAPS);
      y_c[i] = data_i[i] ^ fb;
      // The register always tracks line bits: scrambled output on TX, received bits on RX.
      shift_in = (mode_i == MODE_DESCRAMBLE) ? data_i[i] : y_c[i];
      s        = {s[LFSR_LEN-2:0], shift_in};
    end
    state_o = s;
    y_o     = y_c;
  end

endmodule

// File: rtl/lfsr_scrambler_par.sv
// Parallel self-synchronising scrambler/descrambler with one registered output
// stage. Optional SCRAMBLER_BYPASS_EN adds a per-beat bypass input.
import lfsr_scrambler_pkg::*;

module lfsr_scrambler_par #(
  parameter int                  LFSR_LEN = DEFAULT_LFSR_LEN,
  parameter logic [LFSR_LEN-1:0] TAPS     = DEFAULT_TAPS,
  parameter int                  DATA_W   = DEFAULT_DATA_W,
  parameter logic [LFSR_LEN-1:0] SEED     = DEFAULT_SEED
) (
  input  logic                clk,
  input  logic                reset,
`ifdef SCRAMBLER_BYPASS_EN
  input  logic                bypass,
`endif
  input  logic                mode,
  input  logic                seed_load,
  input  logic [LFSR_LEN-1:0] seed_in,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [LFSR_LEN-1:0] state_out
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; valid never drops and data never changes while waiting for ready.

  logic [LFSR_LEN-1:0] state_q, state_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [LFSR_LEN-1:0] step_state;
  logic [DATA_W-1:0]   step_y;
  logic                accept;

  lfsr_step_unroll #(
    .LFSR_LEN (LFSR_LEN),
    .TAPS     (TAPS),
    .DATA_W   (DATA_W)
  ) u_step (
    .state_i (state_q),
    .data_i  (in_data),
    .mode_i  (mode),
    .state_o (step_state),
    .y_o     (step_y)
  );

  // No skid buffer: a stalled output stage stalls the input.
  assign in_ready = !seed_load && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (seed_load) begin
      state_d = seed_in;
    end else if (accept) begin
      state_d = step_state;
    end
    if (accept) begin
      out_valid_d = 1'b1;
`ifdef SCRAMBLER_BYPASS_EN
      // LFSR still advances on bypassed beats so both link ends stay in lockstep.
      out_data_d  = bypass ? in_data : step_y;
`else
      out_data_d  = step_y;
`endif
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SEED;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign state_out = state_q;

endmodule

// File: doc/lfsr_scrambler_par.md
Name: lfsr_scrambler_par

Overview:
Parametrised, multi-bit-per-clock self-synchronising (multiplicative) scrambler/descrambler. It is the successor to the 1-bit-per-clock x^7+x^4+1 scrambler.
- Processes DATA_W bits per beat, with configurable LFSR length, taps and seed.
- Mode is runtime-selectable: scramble or descramble.
- Valid/ready handshake on both sides, with a registered output stage.
- Sits between the framer and the serialiser on TX, and between the deserialiser and the deframer on RX.

Parameters:
LFSR_LEN, 7, LFSR state width in bits.
TAPS, 7'b1001000, feedback tap mask over state (bit k set means state[k] XORs into feedback); default gives x^7+x^4+1.
DATA_W, 8, bits processed per accepted beat.
SEED, 7'b1010000, state loaded on reset; TX and RX instances must use the same value.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
mode  in  1  0 = scramble, 1 = descramble; sampled with each accepted beat
seed_load  in  1  load seed_in into state this cycle
seed_in  in  LFSR_LEN  runtime seed value
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat
in_data  in  DATA_W  input beat; bit 0 is first in time
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts
out_data  out  DATA_W  processed beat; bit 0 is first in time
state_out  out  LFSR_LEN  current LFSR state

Behaviour:
- Reset values:
  - state_out = SEED.
  - out_valid = 0.
  - out_data = 0.
  - in_ready = 1 on the cycle after reset deasserts.
- Per-bit function, applied for i = 0..DATA_W-1 in sequence within one beat, combinationally unrolled:
  - p = XOR-reduce(state & TAPS).
  - y[i] = d[i] ^ p.
  - Scramble: the shift-in bit is y[i].
  - Descramble: the shift-in bit is d[i] (the received bit).
  - State update: state <= {state[LFSR_LEN-2:0], shift-in bit}.
- Accept: a beat is accepted when in_valid && in_ready.
  - On accept, state_out advances by DATA_W bit-steps.
  - out_data is registered from y.
  - out_valid is set to 1.
- Latency: exactly 1 clock from acceptance to out_valid.
- Throughput: 1 beat/clock while out_ready = 1.
- in_ready = !seed_load && (!out_valid || out_ready). This is a single output register with no skid buffer.
- Output hold: while out_valid && !out_ready, out_data and out_valid hold stable and state_out does not advance.
- out_valid clears when out_valid && out_ready and no new beat is accepted in the same cycle.
- seed_load:
  - Takes priority over everything except reset.
  - state <= seed_in.
  - in_ready is forced to 0 that cycle, so no beat is accepted.
  - A pending output is unaffected and may still drain.
- Reset mid-stream: the pending output beat is discarded (out_valid = 0) and state returns to SEED.
- Mode changes may occur on any beat. Each beat uses the mode value sampled with it; there is no extra state.
- Invalid parameter combinations are not supported and need not be handled:
  - TAPS == 0.
  - TAPS bit LFSR_LEN-1 clear.
  - DATA_W < 1.

Optional Feature:
- Macro: SCRAMBLER_BYPASS_EN.
- When defined:
  - Adds input port bypass (1 bit), sampled with each beat.
  - When bypass = 1, out_data = in_data unmodified, but the LFSR still advances as if the beat were processed in the current mode. This keeps TX and RX in lockstep.
- When undefined:
  - No bypass port.
  - Data is always processed.

Decomposition:
- Package lfsr_scrambler_pkg holds:
  - mode encoding constants MODE_SCRAMBLE = 1'b0 and MODE_DESCRAMBLE = 1'b1.
  - Default poly/seed constants for x^7+x^4+1 (TAPS 7'b1001000, SEED 7'b1010000).
- One sub-module: lfsr_step_unroll.
  - Purely combinational.
  - Inputs: state, data, mode.
  - Outputs: next state and y.
  - Parametrised by LFSR_LEN, TAPS, DATA_W.
- The top module holds the state register, output register and handshake.

Test Plan:
- Golden vector: reset, scramble, in_data = 8'h00 -> out_data = 8'hD5 one cycle later; state_out = 7'h2B.
- Round trip: a scrambler instance feeds a descrambler instance, both with SEED = 7'h50. Send 256 random beats -> descrambler out_data equals the original sequence with 2-cycle total latency. Also check descrambling 8'hD5 from seed 7'h50 gives 8'h00 and state 7'h2B.
- Self-sync: the descrambler is seeded with 7'h00 while the scrambler is seeded with 7'h50 -> after the first beat (≥ 7 bits) all subsequent outputs match; only the first beat may differ.
- Backpressure: out_ready = 0 for 5 cycles with in_valid = 1 -> in_ready = 0, out_data stable, state_out frozen; on release the stream continues with no loss or duplication.
- seed_load plus in_valid in the same cycle -> beat not accepted, state_out = seed_in next cycle; the beat is then accepted and processed from seed_in.
- Reset asserted while out_valid = 1 and out_ready = 0 -> next cycle out_valid = 0 and state_out = 7'h50. With SCRAMBLER_BYPASS_EN, bypass = 1 on 8'hA5 -> out_data = 8'hA5 and state_out advances identically to the non-bypass case.
